// File: rtl/rs.sv
// Unified reservation station: holds dispatched uops until their sources are
// ready, then issues the oldest ready uop through a registered output stage.
package rs_pkg;
  localparam int NUM_SOURCES = 2;
  localparam int PRF_W       = 6;
  localparam int ROB_W       = 7;

  typedef logic [PRF_W-1:0] t_prf_id;
  typedef logic [ROB_W-1:0] t_rob_id;
  typedef logic [1:0]       t_opreg_type;

  localparam t_opreg_type OPREG_NONE = 2'd0;
  localparam t_opreg_type OPREG_GPR  = 2'd1;

  typedef struct packed {
    logic [15:0]                      uinstr;
    t_opreg_type [NUM_SOURCES-1:0]    src_type;
    t_prf_id     [NUM_SOURCES-1:0]    psrc;
    t_prf_id                          pdst;
    t_rob_id                          robid;
  } t_disp_pkt;

  typedef struct packed {
    logic    valid;
    t_rob_id robid;
  } t_nuke_pkt;
endpackage

module rs_chk #(
  parameter int NUM_ENTRIES = 8
) (
  input logic                               clk,
  input logic                               reset,
  input logic                               disp_valid,
  input logic                               stall,
  input logic [NUM_ENTRIES-1:0]             sel,
  input logic [NUM_ENTRIES-1:0]             valid,
  input logic [NUM_ENTRIES*NUM_ENTRIES-1:0] age_flat
);
  // Protocol and structural invariants of the station.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(disp_valid && stall)) else $error("rs: dispatch while stalled");
      assert ($onehot0(sel)) else $error("rs: more than one entry selected");
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          if (i != j && valid[i] && valid[j]) begin
            assert (age_flat[i*NUM_ENTRIES+j] != age_flat[j*NUM_ENTRIES+i])
              else $error("rs: age rows %0d/%0d not antisymmetric", i, j);
          end
        end
      end
    end
  end
endmodule

module rs
  import rs_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_WAKEUPS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  t_nuke_pkt                     nuke_rb1,
  input  logic                          disp_valid_rs0,
  input  t_disp_pkt                     disp_pkt_rs0,
  input  logic [NUM_SOURCES-1:0]        disp_src_rdy_rs0,
  output logic                          rs_stall_rs0,
  input  logic [NUM_WAKEUPS-1:0]        wake_valid_ex,
  input  t_prf_id [NUM_WAKEUPS-1:0]     wake_pdst_ex,
  input  logic                          iss_ready_rs1,
  output logic                          iss_valid_rs1,
  output t_disp_pkt                     iss_pkt_rs1
);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_SOURCES-1:0] src_rdy_q [NUM_ENTRIES];
  logic [NUM_SOURCES-1:0] src_rdy_d [NUM_ENTRIES];
  // age_q[i][j] set means entry j is older than entry i
  logic [NUM_ENTRIES-1:0] age_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] age_d [NUM_ENTRIES];
  t_disp_pkt              pkt_q [NUM_ENTRIES];
  logic                   iss_valid_q, iss_valid_d;
  t_disp_pkt              iss_pkt_q;

  logic [NUM_ENTRIES-1:0] ready_s, sel_s, free_s, alloc_vec_s;
  logic [NUM_SOURCES-1:0] disp_rdy_s;
  logic                   out_load_s, iss_load_s, alloc_s;
  t_disp_pkt              sel_pkt_s;
  logic [NUM_ENTRIES*NUM_ENTRIES-1:0] age_flat_s;
  logic                   unused_s;

  function automatic logic tag_hit(input t_prf_id                  tag,
                                   input logic [NUM_WAKEUPS-1:0]   wv,
                                   input t_prf_id [NUM_WAKEUPS-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WAKEUPS; k++) begin
      hit = hit | (wv[k] & (wt[k] == tag));
    end
    return hit;
  endfunction

  assign rs_stall_rs0  = &valid_q;
  assign iss_valid_rs1 = iss_valid_q;
  assign iss_pkt_rs1   = iss_pkt_q;
  assign unused_s      = ^nuke_rb1.robid;

  assign out_load_s  = ~iss_valid_q | iss_ready_rs1;
  assign iss_load_s  = out_load_s & (|sel_s);
  assign free_s      = out_load_s ? sel_s : '0;
  assign alloc_s     = disp_valid_rs0 & ~rs_stall_rs0 & ~nuke_rb1.valid;
  // Lowest clear bit of valid_q; wraps to zero when full.
  assign alloc_vec_s = {NUM_ENTRIES{alloc_s}} & ~valid_q &
                       (valid_q + {{(NUM_ENTRIES-1){1'b0}}, 1'b1});

  // Readiness and oldest-ready select, all from flopped state.
  always_comb begin
    sel_pkt_s = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ready_s[i] = valid_q[i] & (&src_rdy_q[i]);
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      sel_s[i]  = ready_s[i] & ~(|(age_q[i] & ready_s));
      sel_pkt_s = sel_s[i] ? pkt_q[i] : sel_pkt_s;
    end
  end

  // Source readiness of the uop being written, including same-cycle bypass.
  always_comb begin
    for (int s = 0; s < NUM_SOURCES; s++) begin
      disp_rdy_s[s] = disp_src_rdy_rs0[s]
                    | tag_hit(disp_pkt_rs0.psrc[s], wake_valid_ex, wake_pdst_ex)
                    | (disp_pkt_rs0.src_type[s] == OPREG_NONE);
    end
  end

  // Next-state for entry valids, source readiness, age matrix and issue valid.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int s = 0; s < NUM_SOURCES; s++) begin
        src_rdy_d[i][s] = alloc_vec_s[i] ? disp_rdy_s[s]
                        : (src_rdy_q[i][s]
                           | tag_hit(pkt_q[i].psrc[s], wake_valid_ex, wake_pdst_ex));
      end
      age_d[i] = alloc_vec_s[i] ? (valid_q & ~free_s) : (age_q[i] & ~free_s);
    end
    if (nuke_rb1.valid) begin
      valid_d     = '0;
      iss_valid_d = 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        age_d[i] = '0;
      end
    end else begin
      valid_d     = (valid_q & ~free_s) | alloc_vec_s;
      iss_valid_d = out_load_s ? (|sel_s) : iss_valid_q;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      iss_valid_q <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        src_rdy_q[i] <= '0;
        age_q[i]     <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      iss_valid_q <= iss_valid_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        src_rdy_q[i] <= src_rdy_d[i];
        age_q[i]     <= age_d[i];
      end
    end
  end

  // Payload flops carry no reset; they are qualified by the valids.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (alloc_vec_s[i]) pkt_q[i] <= disp_pkt_rs0;
    end
    if (iss_load_s) iss_pkt_q <= sel_pkt_s;
  end

  // Flattened age matrix for the invariant checker.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      age_flat_s[i*NUM_ENTRIES +: NUM_ENTRIES] = age_q[i];
    end
  end

  rs_chk #(.NUM_ENTRIES(NUM_ENTRIES)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .disp_valid (disp_valid_rs0),
    .stall      (rs_stall_rs0),
    .sel        (sel_s),
    .valid      (valid_q),
    .age_flat   (age_flat_s)
  );

endmodule

// File: tb/tb_rs.sv
// Self-checking bench for rs: directed scenarios plus random traffic, compared
// against a sequence-number based reference model of the station.
module tb_rs;
  import rs_pkg::*;

  localparam int N = 8;
  localparam int W = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  t_nuke_pkt            nuke;
  logic                 disp_valid;
  t_disp_pkt            disp_pkt;
  logic [1:0]           disp_src_rdy;
  logic                 stall;
  logic [W-1:0]         wake_valid;
  t_prf_id [W-1:0]      wake_pdst;
  logic                 iss_ready;
  logic                 iss_valid;
  t_disp_pkt            iss_pkt;

  int errors = 0;
  int checks = 0;
  int rob    = 64;

  rs #(.NUM_ENTRIES(N), .NUM_WAKEUPS(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .nuke_rb1         (nuke),
    .disp_valid_rs0   (disp_valid),
    .disp_pkt_rs0     (disp_pkt),
    .disp_src_rdy_rs0 (disp_src_rdy),
    .rs_stall_rs0     (stall),
    .wake_valid_ex    (wake_valid),
    .wake_pdst_ex     (wake_pdst),
    .iss_ready_rs1    (iss_ready),
    .iss_valid_rs1    (iss_valid),
    .iss_pkt_rs1      (iss_pkt)
  );

  always #5 clk = ~clk;

  // Reference model: unordered slots, age given by dispatch sequence number.
  typedef struct {
    bit        v;
    t_disp_pkt pkt;
    bit [1:0]  rdy;
    int        seq;
  } m_ent_t;

  m_ent_t    m [N];
  bit        m_out_v;
  t_disp_pkt m_out_pkt;
  int        m_seq;

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < N; i++) if (m[i].v) c++;
    return c;
  endfunction

  function automatic bit hit(input t_prf_id tag);
    bit h = 1'b0;
    for (int k = 0; k < W; k++) if (wake_valid[k] && wake_pdst[k] == tag) h = 1'b1;
    return h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i].v = 1'b0;
    m_out_v = 1'b0;
    m_seq   = 0;
  endtask

  task automatic model_step();
    int best, slot;
    bit load, full;
    bit [1:0] r;
    full = (mcount() == N);
    best = -1;
    slot = -1;
    for (int i = 0; i < N; i++)
      if (m[i].v && m[i].rdy == 2'b11 && (best < 0 || m[i].seq < m[best].seq)) best = i;
    if (disp_valid && !full && !nuke.valid)
      for (int i = N-1; i >= 0; i--) if (!m[i].v) slot = i;
    load = !m_out_v || iss_ready;
    if (load) begin
      if (best >= 0) begin
        m_out_v   = 1'b1;
        m_out_pkt = m[best].pkt;
        m[best].v = 1'b0;
      end else begin
        m_out_v = 1'b0;
      end
    end
    for (int i = 0; i < N; i++)
      if (m[i].v)
        for (int s = 0; s < 2; s++) if (hit(m[i].pkt.psrc[s])) m[i].rdy[s] = 1'b1;
    if (slot >= 0) begin
      for (int s = 0; s < 2; s++)
        r[s] = disp_src_rdy[s] || hit(disp_pkt.psrc[s]) || disp_pkt.src_type[s] == OPREG_NONE;
      m[slot].v   = 1'b1;
      m[slot].pkt = disp_pkt;
      m[slot].rdy = r;
      m[slot].seq = m_seq;
      m_seq++;
    end
    if (nuke.valid) begin
      for (int i = 0; i < N; i++) m[i].v = 1'b0;
      m_out_v = 1'b0;
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic check_model(input string tag);
    checks++;
    assert (stall === (mcount() == N)) else begin
      errors++;
      $error("FAIL %s stall: got %0b want %0b", tag, stall, mcount() == N);
    end
    checks++;
    assert (iss_valid === m_out_v) else begin
      errors++;
      $error("FAIL %s iss_valid: got %0b want %0b", tag, iss_valid, m_out_v);
    end
    if (m_out_v) begin
      checks++;
      assert (iss_pkt === m_out_pkt) else begin
        errors++;
        $error("FAIL %s iss_pkt: got rob %0d pdst %0h want rob %0d pdst %0h",
               tag, iss_pkt.robid, iss_pkt.pdst, m_out_pkt.robid, m_out_pkt.pdst);
      end
    end
  endtask

  task automatic cycle(input string tag);
    check_model(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    disp_valid   = 1'b0;
    disp_src_rdy = 2'b00;
    wake_valid   = '0;
    wake_pdst    = '0;
    nuke.valid   = 1'b0;
    nuke.robid   = '0;
  endtask

  function automatic t_disp_pkt mk(input int r, input int p0, input int p1,
                                   input bit none0, input bit none1);
    t_disp_pkt p;
    p.uinstr      = 16'($urandom);
    p.src_type[0] = none0 ? OPREG_NONE : OPREG_GPR;
    p.src_type[1] = none1 ? OPREG_NONE : OPREG_GPR;
    p.psrc[0]     = t_prf_id'(p0);
    p.psrc[1]     = t_prf_id'(p1);
    p.pdst        = t_prf_id'(r + 7);
    p.robid       = t_rob_id'(r);
    return p;
  endfunction

  task automatic disp(input t_disp_pkt p, input logic [1:0] rdy);
    disp_valid   = 1'b1;
    disp_pkt     = p;
    disp_src_rdy = rdy;
  endtask

  // Reset asserted while reset is already 1 or mid-cycle; released off-edge.
  task automatic do_reset();
    idle();
    reset = 1'b1;
    #2;
    expect_val("reset_stall", stall, 0);
    expect_val("reset_iss_valid", iss_valid, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    iss_ready  = 1'b1;
    disp_pkt   = '0;
    idle();
    #10;
    do_reset();

    // Single ready uop: visible two cycles after dispatch, then gone.
    disp(mk(1, 1, 2, 0, 0), 2'b11);
    cycle("t1_c0");
    idle();
    cycle("t1_c1");
    expect_val("t1_valid_c2", iss_valid, 1);
    expect_val("t1_rob_c2", iss_pkt.robid, 1);
    cycle("t1_c2");
    expect_val("t1_valid_c3", iss_valid, 0);
    cycle("t1_c3");

    // Younger ready uop overtakes older blocked one; wake releases the older.
    disp(mk(2, 5, 6, 0, 0), 2'b10);
    cycle("t2_c0");
    disp(mk(3, 7, 8, 0, 0), 2'b11);
    cycle("t2_c1");
    idle();
    cycle("t2_c2");
    expect_val("t2_b_first", iss_pkt.robid, 3);
    cycle("t2_c3");
    wake_valid   = 2'b01;
    wake_pdst[0] = 6'h05;
    cycle("t2_c4");
    idle();
    expect_val("t2_gap_c5", iss_valid, 0);
    cycle("t2_c5");
    expect_val("t2_a_valid", iss_valid, 1);
    expect_val("t2_a_rob", iss_pkt.robid, 2);
    cycle("t2_c6");

    // Fill all entries with blocked uops, then wake them two tags per cycle.
    for (int i = 0; i < N; i++) begin
      disp(mk(10 + i, 16 + i, 16 + i, 0, 0), 2'b00);
      cycle("t3_fill");
    end
    idle();
    expect_val("t3_full_stall", stall, 1);
    for (int w = 0; w < 4; w++) begin
      wake_valid   = 2'b11;
      wake_pdst[0] = t_prf_id'(16 + 2*w);
      wake_pdst[1] = t_prf_id'(17 + 2*w);
      if (w == 1) expect_val("t3_stall_issue_cycle", stall, 1);
      if (w == 2) expect_val("t3_stall_released", stall, 0);
      cycle("t3_wake");
    end
    idle();
    for (int i = 0; i < 12; i++) cycle("t3_drain");

    // Same-cycle wakeup bypass into the written entry.
    disp(mk(30, 40, 33, 0, 0), 2'b01);
    wake_valid   = 2'b10;
    wake_pdst[1] = 6'h21;
    cycle("t4_c0");
    idle();
    cycle("t4_c1");
    expect_val("t4_bypass_valid", iss_valid, 1);
    expect_val("t4_bypass_rob", iss_pkt.robid, 30);
    cycle("t4_c2");
    cycle("t4_c3");

    // Back-pressure: oldest uop held stable, the rest drain in age order.
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(mk(40 + i, 1, 2, 0, 0), 2'b11);
      cycle("t5_disp");
    end
    idle();
    cycle("t5_hold");
    expect_val("t5_held_rob", iss_pkt.robid, 40);
    cycle("t5_hold2");
    iss_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle("t5_drain");

    // Nuke with a held output and five blocked entries; nuke-cycle dispatch dropped.
    iss_ready = 1'b0;
    disp(mk(50, 1, 2, 0, 0), 2'b11);
    cycle("t6_disp");
    for (int i = 0; i < 5; i++) begin
      disp(mk(51 + i, 48 + i, 48 + i, 0, 0), 2'b00);
      cycle("t6_fill");
    end
    disp(mk(56, 1, 2, 0, 0), 2'b11);
    nuke.valid = 1'b1;
    cycle("t6_nuke");
    idle();
    iss_ready = 1'b1;
    expect_val("t6_nuke_stall", stall, 0);
    expect_val("t6_nuke_valid", iss_valid, 0);
    for (int i = 0; i < 5; i++) begin
      wake_valid   = 2'b01;
      wake_pdst[0] = t_prf_id'(48 + i);
      cycle("t6_post");
    end
    idle();
    for (int i = 0; i < 3; i++) cycle("t6_quiet");

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1 && mcount() < N) begin
        disp(mk(rob, $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0), 2'($urandom));
        rob = (rob + 1) % 128;
      end
      wake_valid   = 2'($urandom);
      wake_pdst[0] = t_prf_id'($urandom_range(0, 15));
      wake_pdst[1] = t_prf_id'($urandom_range(0, 15));
      iss_ready    = ($urandom_range(0, 3) != 0);
      nuke.valid   = ($urandom_range(0, 63) == 0);
      cycle("rand");
      if (c == 400) do_reset();
    end
    idle();
    iss_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle("tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
